// File: rtl/afu_mem_responder.sv
// afu_mem_responder: responder end of the AFU cache-line request/response interface.
// Define AFU_MEM_OOR_CHECK_EN to flag and suppress accesses beyond the internal memory.
module afu_mem_responder #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MEM_AW      = 6,
  parameter int FIFO_AW     = 3,
  parameter int AF_SLACK    = 2,
  parameter int RD_LAT      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic [1:0]             overflow,
  output logic                   oor_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LINES = 1 << MEM_AW;
  localparam int RQ_W  = ADDR_LMT + MDATA;
  localparam int WQ_W  = ADDR_LMT + MDATA + CACHE_WIDTH;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] AF_LVL   = (FIFO_AW+1)'(DEPTH - AF_SLACK);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);

  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } last_t;

  last_t                  last_q, last_d;
  logic                   serve_rd, serve_wr;

  logic [RQ_W-1:0]        rq_mem [DEPTH];
  logic [FIFO_AW-1:0]     rq_wp, rq_rp;
  logic [FIFO_AW:0]       rq_cnt;
  logic                   rq_empty, rq_full, rq_push, rq_pop;
  logic [ADDR_LMT-1:0]    rq_head_addr;
  logic [MDATA-1:0]       rq_head_mdata;

  logic [WQ_W-1:0]        wq_mem [DEPTH];
  logic [FIFO_AW-1:0]     wq_wp, wq_rp;
  logic [FIFO_AW:0]       wq_cnt;
  logic                   wq_empty, wq_full, wq_push, wq_pop;
  logic [ADDR_LMT-1:0]    wq_head_addr;
  logic [MDATA-1:0]       wq_head_mdata;
  logic [CACHE_WIDTH-1:0] wq_head_data;

  logic [CACHE_WIDTH-1:0] mem [LINES];
  logic                   rd_oor, wr_oor;
  logic [CACHE_WIDTH-1:0] rd_svc_data;

  logic                   rd_vld_pre;
  logic [MDATA-1:0]       rd_mdata_pre;
  logic [CACHE_WIDTH-1:0] rd_data_pre;

  // Read request queue
  assign rq_empty = (rq_cnt == '0);
  assign rq_full  = (rq_cnt == FULL_LVL);
  assign rq_pop   = serve_rd;
  assign rq_push  = rd_req_en && (!rq_full || rq_pop);
  assign {rq_head_addr, rq_head_mdata} = rq_mem[rq_rp];
  assign rd_req_almostfull = (rq_cnt >= AF_LVL);

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wp] <= {rd_req_addr, rd_req_mdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wp  <= '0;
      rq_rp  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + PTR_ONE;
      if (rq_pop)  rq_rp <= rq_rp + PTR_ONE;
      case ({rq_push, rq_pop})
        2'b10:   rq_cnt <= rq_cnt + CNT_ONE;
        2'b01:   rq_cnt <= rq_cnt - CNT_ONE;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  // Write request queue
  assign wq_empty = (wq_cnt == '0);
  assign wq_full  = (wq_cnt == FULL_LVL);
  assign wq_pop   = serve_wr;
  assign wq_push  = wr_req_en && (!wq_full || wq_pop);
  assign {wq_head_addr, wq_head_mdata, wq_head_data} = wq_mem[wq_rp];
  assign wr_req_almostfull = (wq_cnt >= AF_LVL);

  always_ff @(posedge clk) begin
    if (wq_push) wq_mem[wq_wp] <= {wr_req_addr, wr_req_mdata, wr_req_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wq_wp  <= '0;
      wq_rp  <= '0;
      wq_cnt <= '0;
    end else begin
      if (wq_push) wq_wp <= wq_wp + PTR_ONE;
      if (wq_pop)  wq_rp <= wq_rp + PTR_ONE;
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt <= wq_cnt + CNT_ONE;
        2'b01:   wq_cnt <= wq_cnt - CNT_ONE;
        default: wq_cnt <= wq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 2'b00;
    end else begin
      if (rd_req_en && rq_full && !rq_pop) overflow[0] <= 1'b1;
      if (wr_req_en && wq_full && !wq_pop) overflow[1] <= 1'b1;
    end
  end

  // Arbiter: a tie goes to the queue not served last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= LAST_WR;
    else          last_q <= last_d;
  end

  always_comb begin
    serve_rd = 1'b0;
    serve_wr = 1'b0;
    last_d   = last_q;
    if (!rq_empty && (wq_empty || last_q == LAST_WR)) begin
      serve_rd = 1'b1;
      last_d   = LAST_RD;
    end else if (!wq_empty) begin
      serve_wr = 1'b1;
      last_d   = LAST_WR;
    end
  end

`ifdef AFU_MEM_OOR_CHECK_EN
  assign rd_oor  = |rq_head_addr[ADDR_LMT-1:MEM_AW];
  assign wr_oor  = |wq_head_addr[ADDR_LMT-1:MEM_AW];
  assign oor_err = (serve_rd && rd_oor) || (serve_wr && wr_oor);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{rq_head_addr[ADDR_LMT-1:MEM_AW], wq_head_addr[ADDR_LMT-1:MEM_AW]};
  assign rd_oor  = 1'b0;
  assign wr_oor  = 1'b0;
  assign oor_err = 1'b0;
`endif

  // Line memory: not reset, contents survive reset_n
  always_ff @(posedge clk) begin
    if (serve_wr && !wr_oor) mem[wq_head_addr[MEM_AW-1:0]] <= wq_head_data;
  end

  assign rd_svc_data = rd_oor ? '0 : mem[rq_head_addr[MEM_AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_rsp0_valid <= 1'b0;
      wr_rsp1_valid <= 1'b0;
      wr_rsp0_mdata <= '0;
      wr_rsp1_mdata <= '0;
    end else begin
      wr_rsp0_valid <= serve_wr && !wq_head_addr[0];
      wr_rsp1_valid <= serve_wr &&  wq_head_addr[0];
      if (serve_wr && !wq_head_addr[0]) wr_rsp0_mdata <= wq_head_mdata;
      if (serve_wr &&  wq_head_addr[0]) wr_rsp1_mdata <= wq_head_mdata;
    end
  end

  // Read latency pipeline: RD_LAT-1 internal stages feeding the output register
  generate
    if (RD_LAT > 1) begin : g_rd_pipe
      logic                   vld_p   [RD_LAT-1];
      logic [MDATA-1:0]       mdata_p [RD_LAT-1];
      logic [CACHE_WIDTH-1:0] data_p  [RD_LAT-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < RD_LAT-1; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= serve_rd;
          for (int i = 1; i < RD_LAT-1; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        mdata_p[0] <= rq_head_mdata;
        data_p[0]  <= rd_svc_data;
        for (int i = 1; i < RD_LAT-1; i++) begin
          mdata_p[i] <= mdata_p[i-1];
          data_p[i]  <= data_p[i-1];
        end
      end

      assign rd_vld_pre   = vld_p[RD_LAT-2];
      assign rd_mdata_pre = mdata_p[RD_LAT-2];
      assign rd_data_pre  = data_p[RD_LAT-2];
    end else begin : g_rd_direct
      assign rd_vld_pre   = serve_rd;
      assign rd_mdata_pre = rq_head_mdata;
      assign rd_data_pre  = rd_svc_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_mdata <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_vld_pre;
      if (rd_vld_pre) begin
        rd_rsp_mdata <= rd_mdata_pre;
        rd_rsp_data  <= rd_data_pre;
      end
    end
  end

endmodule

// File: tb/tb_afu_mem_responder.sv
// Testbench for afu_mem_responder: directed and random traffic checked against a
// transaction-level model of queues, alternating arbitration and a line memory.
module tb_afu_mem_responder;

  localparam int ADDR_LMT = 20;
  localparam int MDATA    = 14;
  localparam int CW       = 512;
  localparam int MEM_AW   = 6;
  localparam int FIFO_AW  = 3;
  localparam int AF_SLACK = 2;
  localparam int RD_LAT   = 4;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int AF_LVL   = DEPTH - AF_SLACK;
  localparam int LINES    = 1 << MEM_AW;

  logic                clk, reset_n;
  logic [ADDR_LMT-1:0] rd_req_addr, wr_req_addr;
  logic [MDATA-1:0]    rd_req_mdata, wr_req_mdata;
  logic                rd_req_en, wr_req_en;
  logic [CW-1:0]       wr_req_data;
  logic                rd_req_almostfull, wr_req_almostfull;
  logic                rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid;
  logic [MDATA-1:0]    rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [CW-1:0]       rd_rsp_data;
  logic [1:0]          overflow;
  logic                oor_err;

  afu_mem_responder #(
    .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW), .MEM_AW(MEM_AW),
    .FIFO_AW(FIFO_AW), .AF_SLACK(AF_SLACK), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .overflow(overflow), .oor_err(oor_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [ADDR_LMT-1:0] addr; logic [MDATA-1:0] mdata; logic [CW-1:0] data; } req_t;
  typedef struct { int due; logic [MDATA-1:0] mdata; logic [CW-1:0] data; bit known; } rrsp_t;
  typedef struct { int due; bit ch; logic [MDATA-1:0] mdata; } wrsp_t;

  req_t         rq[$], wq[$];
  rrsp_t        rexp[$];
  wrsp_t        wexp[$];
  logic [CW-1:0] mem_m [LINES];
  bit           mem_known [LINES];
  bit           prefer_rd;
  logic [1:0]   ovf_m;
  int           cyc, checks, failures;
  int           af_rd_seen, af_wr_seen;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [ADDR_LMT-1:0] a);
`ifdef AFU_MEM_OOR_CHECK_EN
    return (a >> MEM_AW) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [CW-1:0] rnd_line();
    logic [CW-1:0] v;
    for (int i = 0; i < CW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: model the service of this cycle, push requests, then check outputs
  task automatic tick(input bit re, input logic [ADDR_LMT-1:0] ra, input logic [MDATA-1:0] rm,
                      input bit we, input logic [ADDR_LMT-1:0] wa, input logic [MDATA-1:0] wm,
                      input logic [CW-1:0] wd);
    bit    srv_rd, exp_oor, ev;
    int    idx;
    req_t  r;
    rrsp_t re_e;
    wrsp_t we_e;
    exp_oor = 1'b0;
    srv_rd  = (rq.size() != 0) && ((wq.size() == 0) || prefer_rd);
    if (srv_rd) begin
      r = rq.pop_front();
      exp_oor = is_oor(r.addr);
      idx = int'(r.addr[MEM_AW-1:0]);
      re_e.due   = cyc + RD_LAT;
      re_e.mdata = r.mdata;
      re_e.data  = exp_oor ? '0 : mem_m[idx];
      re_e.known = exp_oor || mem_known[idx];
      rexp.push_back(re_e);
      prefer_rd = 1'b0;
    end else if (wq.size() != 0) begin
      r = wq.pop_front();
      exp_oor = is_oor(r.addr);
      idx = int'(r.addr[MEM_AW-1:0]);
      if (!exp_oor) begin
        mem_m[idx]     = r.data;
        mem_known[idx] = 1'b1;
      end
      we_e.due   = cyc + 1;
      we_e.ch    = r.addr[0];
      we_e.mdata = r.mdata;
      wexp.push_back(we_e);
      prefer_rd = 1'b1;
    end
    chk("oor_err", oor_err, exp_oor);

    rd_req_en = re; rd_req_addr = ra; rd_req_mdata = rm;
    wr_req_en = we; wr_req_addr = wa; wr_req_mdata = wm; wr_req_data = wd;
    if (re) begin
      r.addr = ra; r.mdata = rm; r.data = '0;
      if (rq.size() < DEPTH) rq.push_back(r); else ovf_m[0] = 1'b1;
    end
    if (we) begin
      r.addr = wa; r.mdata = wm; r.data = wd;
      if (wq.size() < DEPTH) wq.push_back(r); else ovf_m[1] = 1'b1;
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("rd_almostfull", rd_req_almostfull, rq.size() >= AF_LVL);
    chk("wr_almostfull", wr_req_almostfull, wq.size() >= AF_LVL);
    chk("overflow", overflow, ovf_m);

    ev = (rexp.size() != 0) && (rexp[0].due == cyc);
    chk("rd_rsp_valid", rd_rsp_valid, ev);
    if (ev) begin
      re_e = rexp.pop_front();
      chk("rd_rsp_mdata", rd_rsp_mdata, re_e.mdata);
      if (re_e.known) chk("rd_rsp_data", rd_rsp_data, re_e.data);
    end

    ev = (wexp.size() != 0) && (wexp[0].due == cyc);
    if (ev) begin
      we_e = wexp.pop_front();
      chk("wr_rsp0_valid", wr_rsp0_valid, !we_e.ch);
      chk("wr_rsp1_valid", wr_rsp1_valid, we_e.ch);
      if (we_e.ch) chk("wr_rsp1_mdata", wr_rsp1_mdata, we_e.mdata);
      else         chk("wr_rsp0_mdata", wr_rsp0_mdata, we_e.mdata);
    end else begin
      chk("wr_rsp0_idle", wr_rsp0_valid, 1'b0);
      chk("wr_rsp1_idle", wr_rsp1_valid, 1'b0);
    end
    if (rd_req_almostfull) af_rd_seen++;
    if (wr_req_almostfull) af_wr_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || rexp.size() != 0 || wexp.size() != 0) && n < 100) begin
      idle(1);
      n++;
    end
    chk("drain_bound", n < 100, 1'b1);
  endtask

  task automatic check_reset_state();
    chk("rst_rd_rsp_valid", rd_rsp_valid, 1'b0);
    chk("rst_rd_rsp_mdata", rd_rsp_mdata, '0);
    chk("rst_rd_rsp_data", rd_rsp_data, '0);
    chk("rst_wr_rsp0_valid", wr_rsp0_valid, 1'b0);
    chk("rst_wr_rsp0_mdata", wr_rsp0_mdata, '0);
    chk("rst_wr_rsp1_valid", wr_rsp1_valid, 1'b0);
    chk("rst_wr_rsp1_mdata", wr_rsp1_mdata, '0);
    chk("rst_rd_af", rd_req_almostfull, 1'b0);
    chk("rst_wr_af", wr_req_almostfull, 1'b0);
    chk("rst_overflow", overflow, 2'b00);
    chk("rst_oor_err", oor_err, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rd_req_en = 1'b0;
    wr_req_en = 1'b0;
    #1;
    check_reset_state();
    rq.delete(); wq.delete(); rexp.delete(); wexp.delete();
    prefer_rd = 1'b1;
    ovf_m = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [ADDR_LMT-1:0] a;
    checks = 0; failures = 0; cyc = 0;
    af_rd_seen = 0; af_wr_seen = 0;
    for (int i = 0; i < LINES; i++) mem_known[i] = 1'b0;
    rd_req_addr = '0; rd_req_mdata = '0; rd_req_en = 1'b0;
    wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0; wr_req_en = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Write addr 3, then read it back
    tick(0, '0, '0, 1, 20'd3, 14'h11, {480'h0, 32'h0005_0001});
    idle(1);
    chk("t1_wr_rsp1_valid", wr_rsp1_valid, 1'b1);
    chk("t1_wr_rsp1_mdata", wr_rsp1_mdata, 14'h11);
    tick(1, 20'd3, 14'h22, 0, '0, '0, '0);
    idle(4);
    chk("t1_rd_rsp_valid", rd_rsp_valid, 1'b1);
    chk("t1_rd_rsp_data", rd_rsp_data, {480'h0, 32'h0005_0001});
    chk("t1_rd_rsp_mdata", rd_rsp_mdata, 14'h22);
    drain();

    // Channel selection by addr[0]
    tick(0, '0, '0, 1, 20'd2, 14'h33, rnd_line());
    idle(1);
    chk("t2_wr_rsp0_valid", wr_rsp0_valid, 1'b1);
    chk("t2_wr_rsp1_quiet", wr_rsp1_valid, 1'b0);
    for (int i = 4; i < 8; i++) tick(0, '0, '0, 1, ADDR_LMT'(i), MDATA'(i), rnd_line());
    drain();

    // Fill every line with known data
    for (int i = 0; i < LINES; i++) begin
      while (wq.size() >= AF_LVL) idle(1);
      tick(0, '0, '0, 1, ADDR_LMT'(i), MDATA'($urandom), rnd_line());
    end
    drain();

    // Read and write every cycle while honouring almost-full
    af_rd_seen = 0; af_wr_seen = 0;
    for (int i = 0; i < 40; i++)
      tick(rq.size() < AF_LVL, ADDR_LMT'($urandom_range(0, LINES-1)), MDATA'($urandom),
           wq.size() < AF_LVL, ADDR_LMT'($urandom_range(0, LINES-1)), MDATA'($urandom), rnd_line());
    chk("t3_rd_af_seen", af_rd_seen != 0, 1'b1);
    chk("t3_wr_af_seen", af_wr_seen != 0, 1'b1);
    drain();
    chk("t3_no_overflow", overflow, 2'b00);

    // Overrun the read queue while writes keep competing
    tick(0, '0, '0, 1, 20'd9, 14'h91, rnd_line());
    tick(0, '0, '0, 1, 20'd10, 14'h92, rnd_line());
    for (int i = 0; i < 20; i++)
      tick(1, ADDR_LMT'($urandom_range(0, LINES-1)), MDATA'(14'h100 + i),
           wq.size() < 3, ADDR_LMT'($urandom_range(0, LINES-1)), MDATA'($urandom), rnd_line());
    drain();
    chk("t4_overflow", overflow, 2'b01);

    // Reset with three reads in flight
    tick(1, 20'd11, 14'h201, 0, '0, '0, '0);
    tick(1, 20'd12, 14'h202, 0, '0, '0, '0);
    tick(1, 20'd13, 14'h203, 0, '0, '0, '0);
    idle(1);
    do_reset();
    idle(RD_LAT + 4);
    tick(1, 20'd3, 14'h204, 0, '0, '0, '0);
    drain();

    // Address beyond the memory: zero data with check, alias of line 0 without
    tick(1, 20'h40, 14'h300, 0, '0, '0, '0);
    drain();

    // Random mixed traffic, occasionally ignoring almost-full
    for (int i = 0; i < 300; i++) begin
      a = ADDR_LMT'($urandom_range(0, 2*LINES-1));
      tick(($urandom_range(0, 1) == 1) && (rq.size() < AF_LVL || $urandom_range(0, 7) == 0),
           ADDR_LMT'($urandom_range(0, 2*LINES-1)), MDATA'($urandom),
           ($urandom_range(0, 1) == 1) && (wq.size() < AF_LVL || $urandom_range(0, 7) == 0),
           a, MDATA'($urandom), rnd_line());
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
